vn_serial: RTL
==============

VN_SERIAL -- requirements
Module: vn_serial

Interface
REQ-001 SHALL have parameter INT, default 8, meaning integer bits of the signed two's-complement fixed-point message.
REQ-002 SHALL have parameter FRAC, default 8, meaning fractional bits; message width W = INT+FRAC.
REQ-003 SHALL have parameter DV, default 3, meaning variable-node degree (edges per frame), legal range 2..16.
REQ-004 SHALL have port clk  input  1  rising-edge clock, the single clock of the block.
REQ-005 SHALL have port rst_n  input  1  reset; asynchronous assert, active-low.
REQ-006 SHALL have port ch_llr  input  W  channel LLR, sampled on the first accepted beat of a frame.
REQ-007 SHALL have port in_valid  input  1  c2v beat valid.
REQ-008 SHALL have port in_msg  input  W  check-to-variable message for the current edge.
REQ-009 SHALL have port in_ready  output  1  block accepts a beat.
REQ-010 SHALL have port out_valid  output  1  v2c beat valid.
REQ-011 SHALL have port out_ready  input  1  downstream accepts a beat.
REQ-012 SHALL have port out_msg  output  W  extrinsic variable-to-check message.
REQ-013 SHALL have port out_idx  output  clog2(DV)  edge index of out_msg.
REQ-014 SHALL have port out_last  output  1  high on the beat with out_idx = DV-1.
REQ-015 SHALL have port belief  output  W  a-posteriori LLR of the frame.
REQ-016 SHALL have port hard_bit  output  1  hard decision; 1 when belief < 0.

Function
REQ-017 SHALL run FSM states IDLE, LOAD, EMIT; handshake completes when valid and ready are both high at a clk edge.
REQ-018 SHALL hold in_ready high in IDLE and LOAD, low in EMIT; no frame overlap.
REQ-019 SHALL, on an accepted beat in IDLE, load acc = sext(ch_llr) + sext(in_msg), store in_msg at buf[0], and go to LOAD with edge count 1.
REQ-020 SHALL, on each accepted beat in LOAD, add sext(in_msg) to acc and store it at buf[count]; the DV-th beat moves to EMIT next cycle.
REQ-021 SHALL size acc to W+clog2(DV+1) bits so the sum never overflows.
REQ-022 SHALL assert out_valid in the cycle after the DV-th input beat is accepted (latency 1).
REQ-023 SHALL drive out_msg = clip(acc - buf[k]) for k = 0..DV-1 in order, advancing k only on an output handshake.
REQ-024 SHALL hold out_msg, out_idx, out_last, belief and hard_bit stable while out_valid is high and out_ready is low.
REQ-025 SHALL drive belief = clip(acc) and hard_bit = acc[MSB] throughout EMIT.
REQ-026 SHALL return to IDLE on the out_last handshake; in_ready rises in the same following cycle.
REQ-027 SHALL ignore in_valid while in EMIT; no state change.

Reset
REQ-028 SHALL, while rst_n is low, force state IDLE, count 0, k 0, acc 0, all buf 0, out_valid 0, out_msg 0, out_idx 0, out_last 0, belief 0, hard_bit 0, in_ready 0.
REQ-029 SHALL raise in_ready in the first cycle after rst_n deasserts; reset mid-frame discards the partial frame.

Configuration
REQ-030 SHALL, with VN_SAT_EN defined, saturate clip() to [-2^(W-1), 2^(W-1)-1].
REQ-031 SHALL, without VN_SAT_EN, implement clip() as truncation to the low W bits (wrap-around).

Structure
REQ-032 SHALL take the FSM state enum and the acc-width function from shared package ldpc_pkg.
REQ-033 SHALL implement clip() as sub-module sat_clip (parameters IN_W, OUT_W), instantiated twice (out_msg, belief).

Verification
REQ-034 SHALL cover nominal (W=16, DV=3): ch 0x0100, msgs 0x0080, 0xFF00, 0x0200 -> out_msg 0x0200, 0x0380, 0x0080; belief 0x0280; hard_bit 0.
REQ-035 SHALL cover positive overflow: ch 0x7F00, all msgs 0x7F00 -> out_msg 0x7FFF with VN_SAT_EN, low-16 wrapped value without.
REQ-036 SHALL cover negative saturation: ch 0x8000, msgs 0x8000 -> out_msg and belief 0x8000, hard_bit 1 (VN_SAT_EN).
REQ-037 SHALL cover backpressure: out_ready low 5 cycles on idx 1 -> out_msg 0x0380 held, no beat lost or duplicated.
REQ-038 SHALL cover reset after 2 of 3 input beats -> all outputs 0, next full frame gives REQ-034 results.
REQ-039 SHALL cover in_valid bubbles and in_valid held high during EMIT -> identical results, in_ready 0 in EMIT.

Source files
------------

// File: rtl/ldpc_pkg.sv
// Shared LDPC decoder types: variable-node FSM state encoding and accumulator sizing.
package ldpc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_EMIT = 2'd2
    } vn_state_e;

    // Sum of dv W-bit messages plus the channel LLR never overflows this width.
    function automatic int unsigned acc_width(input int unsigned w, input int unsigned dv);
        return w + $clog2(dv + 1);
    endfunction

endpackage

// File: rtl/vn_serial_if.sv
// Bundle of the vn_serial stream signals; master drives c2v beats, slave is the variable node.
interface vn_serial_if #(
    parameter int unsigned W  = 16,
    parameter int unsigned IW = 2
);
    logic [W-1:0]  ch_llr;
    logic          in_valid;
    logic [W-1:0]  in_msg;
    logic          in_ready;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_msg;
    logic [IW-1:0] out_idx;
    logic          out_last;
    logic [W-1:0]  belief;
    logic          hard_bit;

    modport master (
        output ch_llr, in_valid, in_msg, out_ready,
        input  in_ready, out_valid, out_msg, out_idx, out_last, belief, hard_bit
    );

    modport slave (
        input  ch_llr, in_valid, in_msg, out_ready,
        output in_ready, out_valid, out_msg, out_idx, out_last, belief, hard_bit
    );
endinterface

// File: rtl/vn_serial_sat_clip.sv
// Signed narrowing IN_W -> OUT_W: saturating when VN_SAT_EN is defined, wrap-around otherwise.
module sat_clip #(
    parameter int unsigned IN_W  = 18,
    parameter int unsigned OUT_W = 16
) (
    input  logic [IN_W-1:0]  i_d,
    output logic [OUT_W-1:0] o_q
);
`ifdef VN_SAT_EN
    logic w_ovf;

    // Out of range whenever the dropped bits are not all copies of the kept sign bit.
    assign w_ovf = (i_d[IN_W-1:OUT_W-1] != {(IN_W-OUT_W+1){i_d[IN_W-1]}});

    always_comb begin
        o_q = i_d[OUT_W-1:0];
        if (w_ovf) begin
            o_q = i_d[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
        end
    end
`else
    logic w_unused_hi;

    assign o_q         = i_d[OUT_W-1:0];
    assign w_unused_hi = ^i_d[IN_W-1:OUT_W];
`endif
endmodule

// File: rtl/vn_serial.sv
// Serial LDPC variable node: accumulates DV c2v beats, then emits DV extrinsic v2c beats.
// Optional saturation of outputs is enabled by defining VN_SAT_EN.
module vn_serial
    import ldpc_pkg::*;
#(
    parameter  int unsigned INT  = 8,
    parameter  int unsigned FRAC = 8,
    parameter  int unsigned DV   = 3,
    localparam int unsigned W    = INT + FRAC,
    localparam int unsigned IW   = $clog2(DV)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [W-1:0]  ch_llr,
    input  logic          in_valid,
    input  logic [W-1:0]  in_msg,
    output logic          in_ready,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_msg,
    output logic [IW-1:0] out_idx,
    output logic          out_last,
    output logic [W-1:0]  belief,
    output logic          hard_bit
);
    localparam int unsigned AW = acc_width(W, DV);

    vn_state_e     r_state;
    logic [AW-1:0] r_acc;
    logic [W-1:0]  r_buf [DV];
    logic [IW-1:0] r_cnt;
    logic [IW-1:0] r_k;
    logic          r_in_ready;

    logic          w_in_fire;
    logic          w_out_fire;
    logic [AW-1:0] w_msg_ext;
    logic [AW-1:0] w_ch_ext;
    logic [AW-1:0] w_buf_ext;
    logic [AW-1:0] w_diff;

    assign w_in_fire  = in_valid & r_in_ready;
    assign w_out_fire = out_valid & out_ready;
    assign w_msg_ext  = {{(AW-W){in_msg[W-1]}}, in_msg};
    assign w_ch_ext   = {{(AW-W){ch_llr[W-1]}}, ch_llr};
    assign w_buf_ext  = {{(AW-W){r_buf[r_k][W-1]}}, r_buf[r_k]};
    assign w_diff     = r_acc - w_buf_ext;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_k        <= '0;
            r_in_ready <= 1'b0;
            for (int unsigned i = 0; i < DV; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_in_ready <= 1'b1;
                    if (w_in_fire) begin
                        r_acc    <= w_ch_ext + w_msg_ext;
                        r_buf[0] <= in_msg;
                        r_cnt    <= IW'(1);
                        r_state  <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_in_ready <= 1'b1;
                    if (w_in_fire) begin
                        r_acc        <= r_acc + w_msg_ext;
                        r_buf[r_cnt] <= in_msg;
                        if (r_cnt == IW'(DV - 1)) begin
                            r_cnt      <= '0;
                            r_k        <= '0;
                            r_in_ready <= 1'b0;
                            r_state    <= ST_EMIT;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                ST_EMIT: begin
                    r_in_ready <= 1'b0;
                    if (w_out_fire) begin
                        if (r_k == IW'(DV - 1)) begin
                            r_k        <= '0;
                            r_in_ready <= 1'b1;
                            r_state    <= ST_IDLE;
                        end else begin
                            r_k <= r_k + 1'b1;
                        end
                    end
                end
                default: begin
                    r_in_ready <= 1'b0;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = (r_state == ST_EMIT);
    assign out_idx   = r_k;
    assign out_last  = out_valid && (r_k == IW'(DV - 1));
    assign hard_bit  = r_acc[AW-1];

    sat_clip #(.IN_W(AW), .OUT_W(W)) u_clip_msg (
        .i_d (w_diff),
        .o_q (out_msg)
    );

    sat_clip #(.IN_W(AW), .OUT_W(W)) u_clip_bel (
        .i_d (r_acc),
        .o_q (belief)
    );
endmodule
